// File: rtl/tapa_sched_pkg.sv
// Shared definitions for the TAPA global scheduler: state encoding and default widths.
package tapa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    RUN   = 2'b11,
    DONE  = 2'b10
  } sched_state_e;

  localparam int MAX_NUM_TASKS  = 64;
  localparam int DEFAULT_WDOG_W = 32;

endpackage

// File: rtl/tapa_sched_wdog.sv
// Invocation watchdog: counts RUN cycles (saturating) and raises a sticky timeout at the limit.
module tapa_sched_wdog
  import tapa_sched_pkg::*;
#(
  parameter int WDOG_W = DEFAULT_WDOG_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_run,
  input  logic [WDOG_W-1:0] i_limit,
  output logic              o_timeout
);

  logic [WDOG_W-1:0] r_cnt;
  logic [WDOG_W-1:0] w_cnt_next;
  logic              r_timeout;

  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + WDOG_W'(1);

  // The compare only fires on a RUN increment, so a limit changed after the run cannot trip it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_run) begin
      r_cnt <= w_cnt_next;
      if ((i_limit != '0) && (w_cnt_next == i_limit)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/tapa_global_fsm_sched.sv
// Global start/done scheduler for one TAPA kernel invocation.
// Optional watchdog enabled by defining TAPA_GLOBAL_FSM_WDOG_EN.
module tapa_global_fsm_sched
  import tapa_sched_pkg::*;
#(
  parameter int NUM_TASKS = 4,
  parameter int SCALAR_W  = 96,
  parameter int WDOG_W    = DEFAULT_WDOG_W
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  input  logic [SCALAR_W-1:0]  s_scalar_in,
  output logic [SCALAR_W-1:0]  s_scalar_out,
  input  logic [NUM_TASKS-1:0] task_is_done,
  output logic                 global_fsm_ap_start,
  output logic                 global_fsm_ap_done,
  output logic [NUM_TASKS-1:0] done_mask,
  input  logic [WDOG_W-1:0]    wdog_limit,
  output logic                 wdog_timeout
);

  sched_state_e         r_state;
  sched_state_e         w_state_next;
  logic [SCALAR_W-1:0]  r_scalar;
  logic [NUM_TASKS-1:0] r_done_mask;
  logic [NUM_TASKS-1:0] w_mask_merged;
  logic                 w_accept;
  logic                 w_run;

  assign w_accept      = (r_state == IDLE) && ap_start;
  assign w_run         = (r_state == RUN);
  assign w_mask_merged = r_done_mask | task_is_done;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // All host and task-facing handshakes decode from the state register only.
  always_comb begin
    w_state_next        = r_state;
    ap_idle             = 1'b0;
    ap_ready            = 1'b0;
    ap_done             = 1'b0;
    global_fsm_ap_start = 1'b0;
    global_fsm_ap_done  = 1'b0;
    case (r_state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) w_state_next = START;
      end
      START: begin
        ap_ready            = 1'b1;
        global_fsm_ap_start = 1'b1;
        w_state_next        = RUN;
      end
      RUN: begin
        if (&w_mask_merged) w_state_next = DONE;
      end
      DONE: begin
        ap_done            = 1'b1;
        global_fsm_ap_done = 1'b1;
        w_state_next       = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_scalar    <= '0;
      r_done_mask <= '0;
    end else if (w_accept) begin
      r_scalar    <= s_scalar_in;
      r_done_mask <= '0;
    end else if (w_run) begin
      r_done_mask <= w_mask_merged;
    end
  end

  assign s_scalar_out = r_scalar;
  assign done_mask    = r_done_mask;

`ifdef TAPA_GLOBAL_FSM_WDOG_EN
  tapa_sched_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .i_clk     (ap_clk),
    .i_rst_n   (ap_rst_n),
    .i_clear   (w_accept),
    .i_run     (w_run),
    .i_limit   (wdog_limit),
    .o_timeout (wdog_timeout)
  );
`else
  logic w_unused_wdog_limit;
  assign w_unused_wdog_limit = ^wdog_limit;
  assign wdog_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_tapa_global_fsm_sched.sv
// Self-checking bench for tapa_global_fsm_sched: directed and randomized invocations
// checked against a per-invocation timeline model.
module tb_tapa_global_fsm_sched;

  localparam int NT = 4;
  localparam int SW = 96;
  localparam int WW = 32;
  localparam int NEVER = 100000;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_idle;
  logic [SW-1:0] s_scalar_in;
  logic [SW-1:0] s_scalar_out;
  logic [NT-1:0] task_is_done;
  logic          global_fsm_ap_start;
  logic          global_fsm_ap_done;
  logic [NT-1:0] done_mask;
  logic [WW-1:0] wdog_limit;
  logic          wdog_timeout;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_inv = 0;
  int            done_pulses = 0;
  logic [SW-1:0] exp_scalar;
  bit            last_wd;
  int            t_arr[NT];
  int            d_arr[NT];

  tapa_global_fsm_sched #(
    .NUM_TASKS (NT),
    .SCALAR_W  (SW),
    .WDOG_W    (WW)
  ) dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .ap_start            (ap_start),
    .ap_ready            (ap_ready),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .s_scalar_in         (s_scalar_in),
    .s_scalar_out        (s_scalar_out),
    .task_is_done        (task_is_done),
    .global_fsm_ap_start (global_fsm_ap_start),
    .global_fsm_ap_done  (global_fsm_ap_done),
    .done_mask           (done_mask),
    .wdog_limit          (wdog_limit),
    .wdog_timeout        (wdog_timeout)
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) begin
    if (ap_done === 1'b1) done_pulses++;
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timeout expected once the number of completed RUN cycles has reached a nonzero limit.
  function automatic bit wd_exp(input int run_elapsed, input logic [WW-1:0] lim);
`ifdef TAPA_GLOBAL_FSM_WDOG_EN
    return (lim != '0) && (longint'(run_elapsed) >= longint'(lim));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_outs(input string ph, input bit idle, input bit start, input bit done,
                          input logic [NT-1:0] mask, input bit wd);
    chk({ph, ".idle"},   SW'(ap_idle),             SW'(idle));
    chk({ph, ".ready"},  SW'(ap_ready),            SW'(start));
    chk({ph, ".gstart"}, SW'(global_fsm_ap_start), SW'(start));
    chk({ph, ".done"},   SW'(ap_done),             SW'(done));
    chk({ph, ".gdone"},  SW'(global_fsm_ap_done),  SW'(done));
    chk({ph, ".mask"},   SW'(done_mask),           SW'(mask));
    chk({ph, ".scalar"}, s_scalar_out,             exp_scalar);
    chk({ph, ".wdog"},   SW'(wdog_timeout),        SW'(wd));
  endtask

  function automatic logic [SW-1:0] rand_scalar();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One invocation from an IDLE cycle back to the following IDLE cycle.
  // t[i]: first RUN cycle (1-based) in which task i drives is_done; d[i]: first cycle it drops again.
  task automatic run_inv(input logic [SW-1:0] sc, input int t[NT], input int d[NT],
                         input logic [WW-1:0] lim, input bit hold);
    int            last_t;
    logic [NT-1:0] m;
    last_t = 0;
    for (int i = 0; i < NT; i++) if (t[i] > last_t) last_t = t[i];

    wdog_limit   = lim;
    s_scalar_in  = sc;
    ap_start     = 1'b1;
    task_is_done = NT'($urandom);
    step();
    exp_scalar = sc;
    chk_outs("start", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    ap_start     = hold ? 1'b1 : 1'($urandom);
    task_is_done = NT'($urandom);
    s_scalar_in  = rand_scalar();
    step();

    for (int k = 1; k <= last_t; k++) begin
      m = '0;
      for (int i = 0; i < NT; i++) if (t[i] <= k - 1) m[i] = 1'b1;
      chk_outs("run", 1'b0, 1'b0, 1'b0, m, wd_exp(k - 1, lim));
      for (int i = 0; i < NT; i++) task_is_done[i] = (k >= t[i]) && (k < d[i]);
      ap_start    = hold ? 1'b1 : 1'($urandom);
      s_scalar_in = rand_scalar();
      step();
    end

    chk_outs("done", 1'b0, 1'b0, 1'b1, '1, wd_exp(last_t, lim));
    ap_start     = hold ? 1'b1 : 1'($urandom);
    task_is_done = NT'($urandom);
    step();
    last_wd = wd_exp(last_t, lim);
    chk_outs("idle", 1'b1, 1'b0, 1'b0, '1, last_wd);
    ap_start     = hold;
    task_is_done = '0;
    n_inv++;
    $display("inv %0d: run_cycles=%0d t=%0d/%0d/%0d/%0d lim=%0d hold=%0d wdog=%0d checks=%0d errors=%0d",
             n_inv, last_t, t[0], t[1], t[2], t[3], lim, hold, last_wd, n_checks, n_errors);
  endtask

  initial begin
    int pulses_before;
    ap_rst_n     = 1'b0;
    ap_start     = 1'b0;
    s_scalar_in  = '0;
    task_is_done = '0;
    wdog_limit   = '0;
    exp_scalar   = '0;
    last_wd      = 1'b0;

    #2;
    chk_outs("rst_hold", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    s_scalar_in  = rand_scalar();
    ap_start     = 1'b1;
    task_is_done = '1;
    repeat (3) step();
    chk_outs("rst_clk", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    ap_start     = 1'b0;
    task_is_done = '0;
    #3 ap_rst_n = 1'b1;

    // Idle with junk on task_is_done: nothing moves.
    for (int c = 0; c < 3; c++) begin
      task_is_done = NT'($urandom);
      step();
      chk_outs("idle_wait", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    end
    task_is_done = '0;

    // Staggered completion with bit 0 glitching low, A5 scalars.
    t_arr = '{3, 7, 5, 12};
    d_arr = '{8, NEVER, NEVER, NEVER};
    run_inv({12{8'hA5}}, t_arr, d_arr, '0, 1'b0);

    // Simultaneous completion on the first RUN cycle: minimum-length invocation, back-to-back.
    t_arr = '{1, 1, 1, 1};
    d_arr = '{NEVER, NEVER, NEVER, NEVER};
    run_inv(rand_scalar(), t_arr, d_arr, '0, 1'b1);
    run_inv(rand_scalar(), t_arr, d_arr, '0, 1'b1);

    // Watchdog limit 20 with the run lasting 30 cycles, then the same run with the watchdog off.
    t_arr = '{30, 10, 25, 30};
    run_inv(rand_scalar(), t_arr, d_arr, 32'd20, 1'b0);
    run_inv(rand_scalar(), t_arr, d_arr, 32'd0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [WW-1:0] lim;
      for (int i = 0; i < NT; i++) begin
        t_arr[i] = $urandom_range(1, 15);
        d_arr[i] = ($urandom_range(0, 1) == 0) ? NEVER : t_arr[i] + $urandom_range(1, 6);
      end
      lim = ($urandom_range(0, 2) == 0) ? '0 : WW'($urandom_range(1, 16));
      run_inv(rand_scalar(), t_arr, d_arr, lim, 1'($urandom));
    end
    ap_start = 1'b0;
    step();

    // Reset asserted mid-RUN, away from any clock edge.
    wdog_limit   = 32'd2;
    s_scalar_in  = rand_scalar();
    ap_start     = 1'b1;
    task_is_done = '0;
    step();
    exp_scalar = s_scalar_in;
    ap_start   = 1'b0;
    repeat (3) step();
    chk_outs("pre_rst_run", 1'b0, 1'b0, 1'b0, '0, wd_exp(2, 32'd2));
    #3 ap_rst_n = 1'b0;
    task_is_done = '1;
    #1;
    exp_scalar = '0;
    last_wd    = 1'b0;
    chk_outs("rst_mid", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    pulses_before = done_pulses;
    repeat (3) step();
    chk("rst_no_done", SW'(done_pulses), SW'(pulses_before));
    #3 ap_rst_n = 1'b1;
    task_is_done = '0;
    step();
    chk_outs("post_rst", 1'b1, 1'b0, 1'b0, '0, 1'b0);

    t_arr = '{2, 4, 1, 3};
    d_arr = '{NEVER, NEVER, 2, NEVER};
    run_inv(rand_scalar(), t_arr, d_arr, 32'd3, 1'b0);
    ap_start = 1'b0;
    step();
    step();
    chk("done_pulse_count", SW'(done_pulses), SW'(n_inv));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
